// File: rtl/fir_result_fifo.sv
// FIR output stage: drops warm-up results, requantizes 2(m+n)-bit results to m+n bits, buffers in a DEPTH-word FIFO.
// Latency: one cycle from an accepted (non-discarded) result to out_valid; out_data is read straight from registers.
// Backpressure: in_ready deasserts when the FIFO is full (warm-up always accepts); it never depends on out_ready.
// Build option: define FIR_RQ_SATURATE_EN to clamp out-of-range words, otherwise the low m+n bits are kept (wrap).
module fir_result_fifo #(
  parameter int n      = 4,
  parameter int m      = 4,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [2*(m+n)-1:0]         in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [m+n-1:0]             out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_sticky
);

  localparam int IW  = 2 * (m + n);
  localparam int OW  = m + n;
  localparam int SW  = IW + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [0:0] ST_WARM = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  // With no warm-up requested the block comes out of reset/flush already running.
  localparam logic [0:0] ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARM;

  localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

  logic [0:0]     state_q, state_d;
  logic [WCW-1:0] warm_q, warm_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [OW-1:0]  mem_q [DEPTH];

  logic                 accept;
  logic                 pop;
  logic                 push;
  logic signed [SW-1:0] rq_sum;
  logic signed [SW-1:0] rq_shift;
  logic                 rq_oor;
  logic [OW-1:0]        rq_word;

  // Handshake terms; in_ready is a function of registered state only.
  always_comb begin
    in_ready  = (state_q == ST_WARM) || (count_q < CW'(DEPTH));
    out_valid = (count_q != '0);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    push      = accept && (state_q == ST_RUN);
  end

  // Round half up at the dropped LSBs, then check that the shifted value fits in OW signed bits.
  always_comb begin
    rq_sum   = {in_data[IW-1], in_data} + (SW'(1) << (n - 1));
    rq_shift = rq_sum >>> n;
    // In range exactly when every bit from the new sign position upward agrees.
    rq_oor   = !((&rq_shift[SW-1:OW-1]) || (~|rq_shift[SW-1:OW-1]));
`ifdef FIR_RQ_SATURATE_EN
    if (rq_oor) begin
      rq_word = rq_shift[SW-1] ? SAT_MIN : SAT_MAX;
    end else begin
      rq_word = rq_shift[OW-1:0];
    end
`else
    rq_word = rq_shift[OW-1:0];
`endif
  end

  // Next-state for warm-up tracking, pointers, occupancy and the overflow flag; flush wins over everything.
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      state_d  = ST_INIT;
      warm_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (accept && (state_q == ST_WARM)) begin
        warm_d = warm_q + 1'b1;
        // The word that completes the warm-up is itself discarded.
        if (warm_d == WCW'(WARMUP)) begin
          state_d = ST_RUN;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (rq_oor) begin
          ovf_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      warm_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful below count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= rq_word;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    out_data   = mem_q[rd_ptr_q];
    count      = count_q;
    ovf_sticky = ovf_q;
  end

endmodule

// File: tb/tb_fir_result_fifo.sv
// Randomized and directed bench for fir_result_fifo against a queue-based reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are checked 1 unit after the next rising edge.
module tb_fir_result_fifo;

  localparam int N      = 4;
  localparam int M      = 4;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        ovf_sticky;

  int checks = 0;
  int failures = 0;

  // Reference model: warm-up words still to drop, queued samples, sticky flag.
  int m_warm;
  int m_q[$];
  bit m_ovf;

  fir_result_fifo #(.n(N), .m(M), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Real-valued rule: value/2^2n rounded half up to a multiple of 2^-n, range [-8, 8 - 1/16].
  function automatic int rq_ref(input logic [15:0] d, output bit oor);
    int v;
    int t;
    int r;
    v = int'($signed(d));
    t = v + 8;
    if (t >= 0) r = t / 16;
    else        r = -((-t + 15) / 16);
    oor = (r < -128) || (r > 127);
`ifdef FIR_RQ_SATURATE_EN
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
`endif
    return r & 32'hFF;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_warm = WARMUP;
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".count"}, 32'(count), 32'(m_q.size()));
    check_val({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    check_val({tag, ".ovf"}, 32'(ovf_sticky), 32'(m_ovf));
    if (m_q.size() != 0) check_val({tag, ".out_data"}, 32'(out_data), 32'(m_q[0]));
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic cycle(input bit vld, input logic [15:0] d, input bit ordy, input bit fl);
    bit exp_rdy;
    bit acc;
    bit pop;
    bit oor;
    int w;
    exp_rdy = (m_warm > 0) || (m_q.size() < DEPTH);
    in_valid = vld;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    #1;
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    acc = vld && exp_rdy;
    pop = ordy && (m_q.size() != 0);
    if (fl) begin
      model_reset();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        if (m_warm > 0) begin
          m_warm--;
        end else begin
          w = rq_ref(d, oor);
          m_q.push_back(w);
          if (oor) m_ovf = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    flush = 1'b0;
    check_outputs("cyc");
  endtask

  task automatic warm_up();
    for (int i = 0; i < WARMUP; i++) cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 3) != 0) r = {{5{r[10]}}, r[10:0]};
    return r;
  endfunction

  initial begin
    logic [15:0] warm_vals [4];
    warm_vals[0] = 16'h0100; warm_vals[1] = 16'h0200;
    warm_vals[2] = 16'h0300; warm_vals[3] = 16'h0400;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.count", 32'(count), 32'd0);
    check_val("rst.out_valid", 32'(out_valid), 32'd0);
    check_val("rst.ovf", 32'(ovf_sticky), 32'd0);
    check_val("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Warm-up discard then first sample.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, warm_vals[i], 1'b1, 1'b0);
      check_val("warm.count", 32'(count), 32'd0);
    end
    cycle(1'b1, 16'h0180, 1'b0, 1'b0);
    check_val("first.out_valid", 32'(out_valid), 32'd1);
    check_val("first.data", 32'(out_data), 32'h18);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Rounding cases.
    cycle(1'b1, 16'h0188, 1'b0, 1'b0);
    check_val("rq.0188", 32'(out_data), 32'h19);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'hFE78, 1'b0, 1'b0);
    check_val("rq.FE78", 32'(out_data), 32'hE8);
    check_val("rq.no_ovf", 32'(ovf_sticky), 32'd0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Out-of-range handling.
    cycle(1'b1, 16'h7F00, 1'b0, 1'b0);
`ifdef FIR_RQ_SATURATE_EN
    check_val("rq.7F00", 32'(out_data), 32'h7F);
`else
    check_val("rq.7F00", 32'(out_data), 32'hF0);
`endif
    check_val("ovf.pos", 32'(ovf_sticky), 32'd1);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'h8000, 1'b0, 1'b0);
`ifdef FIR_RQ_SATURATE_EN
    check_val("rq.8000", 32'(out_data), 32'h80);
`else
    check_val("rq.8000", 32'(out_data), 32'h00);
`endif
    check_val("ovf.neg", 32'(ovf_sticky), 32'd1);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    check_val("flush.ovf", 32'(ovf_sticky), 32'd0);

    // Warm-up overflow never sets the flag.
    cycle(1'b1, 16'h7F00, 1'b0, 1'b0);
    check_val("warm.ovf", 32'(ovf_sticky), 32'd0);
    for (int i = 1; i < WARMUP; i++) cycle(1'b1, 16'h0, 1'b0, 1'b0);

    // Fill, overflow attempt, drain; twice for pointer wrap.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 9; i++) cycle(1'b1, rand_data(), 1'b0, 1'b0);
      check_val("full.count", 32'(count), 32'd8);
      check_val("full.in_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, rand_data(), 1'b1, 1'b0);
      check_val("full.pop_push", 32'(count), 32'd7);
      for (int i = 0; i < 7; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
      check_val("drain.count", 32'(count), 32'd0);
    end

    // Steady stream at count 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_data(), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, rand_data(), 1'b1, 1'b0);
      check_val("stream.count", 32'(count), 32'd3);
    end

    // Flush with accept and pop at count 5.
    cycle(1'b1, rand_data(), 1'b0, 1'b0);
    cycle(1'b1, rand_data(), 1'b0, 1'b0);
    check_val("pre_flush.count", 32'(count), 32'd5);
    cycle(1'b1, 16'h7F00, 1'b1, 1'b1);
    check_val("flush.count", 32'(count), 32'd0);
    check_val("flush.out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < WARMUP; i++) begin
      cycle(1'b1, rand_data(), 1'b1, 1'b0);
      check_val("rewarm.count", 32'(count), 32'd0);
    end
    cycle(1'b1, 16'h0180, 1'b0, 1'b0);
    check_val("rewarm.first", 32'(out_data), 32'h18);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 199) == 0);
    end

    // Asynchronous reset mid-transfer.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_data(), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst.count", 32'(count), 32'd0);
    check_val("arst.out_valid", 32'(out_valid), 32'd0);
    check_val("arst.ovf", 32'(ovf_sticky), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    warm_up();
    for (int i = 0; i < 20; i++) cycle(1'b1, rand_data(), 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
